// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types for the pipeline hazard controller
package pipe_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } ctrl_state_t;

   // Per-stage register controls, shared with the top-level pipeline
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_bubble;
   } stage_ctrl_t;

   localparam stage_ctrl_t STAGE_CTRL_RUN = '{
      pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
      ifid_flush: 1'b0, idex_flush: 1'b0, memwb_bubble: 1'b0
   };

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - stage-side signals of the hazard controller (counters with HAZ_PERF_CNT_EN)
interface pipe_hazard_ctrl_if
`ifdef HAZ_PERF_CNT_EN
#(
   parameter int CNT_W = 32
)
`endif
();
   import pipe_ctrl_pkg::*;

   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_use_rs;
   logic                  id_use_rt;
   logic                  ex_mem_read;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_branch_taken;
   logic                  mem_req;
   logic                  mem_ready;

   logic                  pc_en;
   logic                  ifid_en;
   logic                  idex_en;
   logic                  exmem_en;
   logic                  memwb_en;
   logic                  ifid_flush;
   logic                  idex_flush;
   logic                  memwb_bubble;
   logic                  mem_err;
   logic [1:0]            ctrl_state;
`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0]      stall_cycles;
   logic [CNT_W-1:0]      flush_count;
`endif

   // Pipeline side: supplies stage information, consumes controls
   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd,
             ex_branch_taken, mem_req, mem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, memwb_bubble, mem_err, ctrl_state
`ifdef HAZ_PERF_CNT_EN
      , input stall_cycles, flush_count
`endif
   );

   // Controller side
   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd,
             ex_branch_taken, mem_req, mem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, memwb_bubble, mem_err, ctrl_state
`ifdef HAZ_PERF_CNT_EN
      , output stall_cycles, flush_count
`endif
   );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// rtl/pipe_hazard_ctrl_load_use_detect.sv - load-use dependency compare for one issue port
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_use_rs,
   input  logic                  id_use_rt,
   output logic                  load_use
);

   // A load into r0 never creates a dependency; only real source reads count
   always_comb begin
      load_use = ex_mem_read && (ex_rd != '0) &&
                 ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard controller (optional counters: HAZ_PERF_CNT_EN)
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64
`ifdef HAZ_PERF_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave hz
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   ctrl_state_t       state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_err_q, mem_err_d;
   stage_ctrl_t       ctrl;
   logic              mem_busy;
   logic              load_use;

   load_use_detect u_load_use_detect (
      .ex_mem_read (hz.ex_mem_read),
      .ex_rd       (hz.ex_rd),
      .id_rs       (hz.id_rs),
      .id_rt       (hz.id_rt),
      .id_use_rs   (hz.id_use_rs),
      .id_use_rt   (hz.id_use_rt),
      .load_use    (load_use)
   );

   assign mem_busy = hz.mem_req && !hz.mem_ready;

   // Next state, wait watchdog and Mealy stage controls (ERR > mem_busy > branch > load-use)
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      ctrl       = STAGE_CTRL_RUN;
      case (state_q)
         ERR: begin
            ctrl              = '0;
            ctrl.memwb_bubble = 1'b1;
         end
         RUN, MEM_WAIT: begin
            if (mem_busy) begin
               ctrl.pc_en        = 1'b0;
               ctrl.ifid_en      = 1'b0;
               ctrl.idex_en      = 1'b0;
               ctrl.exmem_en     = 1'b0;
               ctrl.memwb_bubble = 1'b1;
               if (wait_cnt_q == WAIT_LAST) begin
                  state_d    = ERR;
                  mem_err_d  = 1'b1;
                  wait_cnt_d = '0;
               end else begin
                  state_d    = MEM_WAIT;
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end else begin
               // Memory done (or idle): resume and evaluate control hazards this cycle
               state_d    = RUN;
               wait_cnt_d = '0;
               if (hz.ex_branch_taken) begin
                  // Stage registers give flush priority over their still-high enables
                  ctrl.ifid_flush = 1'b1;
                  ctrl.idex_flush = 1'b1;
               end else if (load_use) begin
                  ctrl.pc_en      = 1'b0;
                  ctrl.ifid_en    = 1'b0;
                  ctrl.idex_flush = 1'b1;
               end
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // State, wait counter and sticky error flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign hz.pc_en        = ctrl.pc_en;
   assign hz.ifid_en      = ctrl.ifid_en;
   assign hz.idex_en      = ctrl.idex_en;
   assign hz.exmem_en     = ctrl.exmem_en;
   assign hz.memwb_en     = ctrl.memwb_en;
   assign hz.ifid_flush   = ctrl.ifid_flush;
   assign hz.idex_flush   = ctrl.idex_flush;
   assign hz.memwb_bubble = ctrl.memwb_bubble;
   assign hz.mem_err      = mem_err_q;
   assign hz.ctrl_state   = state_q;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   // Saturating counters; ifid_flush is raised only by an accepted branch
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (!ctrl.pc_en && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if (ctrl.ifid_flush && (flush_count_q != '1)) begin
         flush_count_d = flush_count_q + CNT_W'(1);
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign hz.stall_cycles = stall_cycles_q;
   assign hz.flush_count  = flush_count_q;
`endif

endmodule
